vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 52 +++++
 rtl/vga_delay_line.sv | 34 +++
 rtl/vga_timing_gen.sv | 169 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing types, default 640x480@60 constants and window helper for the
// parametrised VGA timing generator.
package vga_pkg;

  // Default 640x480@60 timing (25.175 MHz pixel clock).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  // Sync pulse active levels.
  localparam logic POL_NEG = 1'b0;
  localparam logic POL_POS = 1'b1;

  typedef struct packed {
    int h_active;
    int h_front;
    int h_sync;
    int h_back;
    int v_active;
    int v_front;
    int v_sync;
    int v_back;
  } vga_timing_t;

  // Totals and half-open sync windows [start, end) in counter space.
  typedef struct packed {
    int h_total;
    int hs_start;
    int hs_end;
    int v_total;
    int vs_start;
    int vs_end;
  } vga_bounds_t;

  // Line/frame order is active, front porch, sync, back porch.
  function automatic vga_bounds_t vga_bounds(input vga_timing_t t);
    vga_bounds_t b;
    b.h_total  = t.h_active + t.h_front + t.h_sync + t.h_back;
    b.hs_start = t.h_active + t.h_front;
    b.hs_end   = t.h_active + t.h_front + t.h_sync;
    b.v_total  = t.v_active + t.v_front + t.v_sync + t.v_back;
    b.vs_start = t.v_active + t.v_front;
    b.vs_end   = t.v_active + t.v_front + t.v_sync;
    return b;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register for the display-domain flags. DEPTH=0 is a
// plain wire so the top can use FETCH_LAT directly as the depth.
module vga_delay_line #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         gclk,
  input  logic         grst,
  input  logic [W-1:0] rst_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] d_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign d_o = d_i;
    end else begin : g_pipe
      logic [DEPTH-1:0][W-1:0] pipe_q;

      // Shift one stage per clock; reset loads every stage with the idle value.
      always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
          pipe_q <= {DEPTH{rst_val_i}};
        end else begin
          pipe_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign d_o = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator. A counter stage issues fetch requests
// with source coordinates; the sync/enable flags are delayed by FETCH_LAT+1
// so they line up exactly with the fetched pixel on r/g/b.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter logic HS_POL    = POL_NEG,
  parameter logic VS_POL    = POL_NEG,
  parameter int   SCALE     = 0,
  parameter int   FETCH_LAT = 2,
  parameter int   CH_W      = 4,
  parameter int   COORD_W   = 10
) (
  input  logic               gclk,
  input  logic               grst,
  input  logic               en_i,
  output logic               hs_o,
  output logic               vs_o,
  output logic               de_o,
  output logic               fr_o,
  output logic [CH_W-1:0]    r_o,
  output logic [CH_W-1:0]    g_o,
  output logic [CH_W-1:0]    b_o,
  output logic               req_o,
  output logic [COORD_W-1:0] src_x_o,
  output logic [COORD_W-1:0] src_y_o,
  output logic               newline_o,
  output logic [COORD_W-1:0] line_o,
  input  logic [3*CH_W-1:0]  pixel_i
);

  localparam vga_timing_t TIM = '{h_active: H_ACTIVE, h_front: H_FRONT,
                                  h_sync: H_SYNC, h_back: H_BACK,
                                  v_active: V_ACTIVE, v_front: V_FRONT,
                                  v_sync: V_SYNC, v_back: V_BACK};
  localparam vga_bounds_t BND = vga_bounds(TIM);
  localparam int H_TOTAL  = BND.h_total;
  localparam int V_TOTAL  = BND.v_total;
  localparam int HS_START = BND.hs_start;
  localparam int HS_END   = BND.hs_end;
  localparam int VS_START = BND.vs_start;
  localparam int VS_END   = BND.vs_end;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int SMASK    = (1 << SCALE) - 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Counter stage: position and the registered fetch-side outputs.
  logic               run_q;
  logic [HW-1:0]      hcnt_q, h_d;
  logic [VW-1:0]      vcnt_q, v_d, v_nx;
  logic               req_q, req_d;
  logic [COORD_W-1:0] sx_q, sx_d, sy_q, sy_d, line_q, line_d;
  logic               nl_q, nl_d;
  logic               fp_q, fp_d;
  logic               hsr_q, hsr_d, vsr_q, vsr_d;

  // Display stage.
  logic [3:0]         dly;
  logic               hs_q, vs_q, de_q, fr_q;
  logic [3*CH_W-1:0]  rgb_q;

  // Next position: hold at (0,0) while disabled and on the first enabled
  // edge, otherwise advance; then derive everything the counter stage drives.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (en_i && run_q) begin
      if (hcnt_q == H_LAST) begin
        v_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        h_d = hcnt_q + 1'b1;
        v_d = vcnt_q;
      end
    end
    v_nx   = (v_d == V_LAST) ? '0 : v_d + 1'b1;
    req_d  = en_i && (int'(h_d) < H_ACTIVE) && (int'(v_d) < V_ACTIVE);
    sx_d   = req_d ? COORD_W'(h_d >> SCALE) : '0;
    sy_d   = req_d ? COORD_W'(v_d >> SCALE) : '0;
    // Announce a source row on the last cycle of the line before it starts.
    nl_d   = en_i && (h_d == H_LAST) && (int'(v_nx) < V_ACTIVE) &&
             ((int'(v_nx) & SMASK) == 0);
    line_d = nl_d ? COORD_W'(v_nx >> SCALE) : line_q;
    fp_d   = en_i && (h_d == '0) && (v_d == '0);
    hsr_d  = (en_i && int'(h_d) >= HS_START && int'(h_d) < HS_END) ? HS_POL : ~HS_POL;
    vsr_d  = (en_i && int'(v_d) >= VS_START && int'(v_d) < VS_END) ? VS_POL : ~VS_POL;
  end

  // Counter-stage registers.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      run_q  <= 1'b0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      req_q  <= 1'b0;
      sx_q   <= '0;
      sy_q   <= '0;
      nl_q   <= 1'b0;
      line_q <= '0;
      fp_q   <= 1'b0;
      hsr_q  <= ~HS_POL;
      vsr_q  <= ~VS_POL;
    end else begin
      run_q  <= en_i;
      hcnt_q <= h_d;
      vcnt_q <= v_d;
      req_q  <= req_d;
      sx_q   <= sx_d;
      sy_q   <= sy_d;
      nl_q   <= nl_d;
      line_q <= line_d;
      fp_q   <= fp_d;
      hsr_q  <= hsr_d;
      vsr_q  <= vsr_d;
    end
  end

  // FETCH_LAT stages here plus the output register below give FETCH_LAT+1.
  vga_delay_line #(
    .DEPTH (FETCH_LAT),
    .W     (4)
  ) u_dly (
    .gclk      (gclk),
    .grst      (grst),
    .rst_val_i ({~HS_POL, ~VS_POL, 2'b00}),
    .d_i       ({hsr_q, vsr_q, req_q, fp_q}),
    .d_o       (dly)
  );

  // Display register: capture the returning pixel when its request arrives.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      fr_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= dly[3];
      vs_q  <= dly[2];
      de_q  <= dly[1];
      fr_q  <= dly[0];
      rgb_q <= dly[1] ? pixel_i : '0;
    end
  end

  assign hs_o      = hs_q;
  assign vs_o      = vs_q;
  assign de_o      = de_q;
  assign fr_o      = fr_q;
  assign r_o       = rgb_q[3*CH_W-1 -: CH_W];
  assign g_o       = rgb_q[2*CH_W-1 -: CH_W];
  assign b_o       = rgb_q[CH_W-1 -: CH_W];
  assign req_o     = req_q;
  assign src_x_o   = sx_q;
  assign src_y_o   = sy_q;
  assign newline_o = nl_q;
  assign line_o    = line_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 24x13 timing set.
// u_a: defaults (FETCH_LAT=2, SCALE=0, negative sync), constant pixel.
// u_l: FETCH_LAT=3, positive sync, pixel = {2'b0,src_x} echoed 3 cycles later.
// u_s: SCALE=1, constant pixel.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VSY = 2, VB = 2;
  localparam int HT = HA + HF + HSY + HB;   // 24
  localparam int VT = VA + VF + VSY + VB;   // 13
  localparam int FT = HT * VT;              // 312
  localparam logic [11:0] PIX_A = 12'h5A3;
  localparam logic [11:0] PIX_S = 12'hFFF;

  logic gclk = 1'b0;
  logic grst = 1'b1;
  logic en   = 1'b0;
  always #5 gclk = ~gclk;

  int nchk = 0;
  int nerr = 0;

  logic       hs_a, vs_a, de_a, fr_a, req_a, nl_a;
  logic [3:0] r_a, g_a, b_a;
  logic [9:0] sx_a, sy_a, ln_a;
  logic       hs_l, vs_l, de_l, fr_l, req_l, nl_l;
  logic [3:0] r_l, g_l, b_l;
  logic [9:0] sx_l, sy_l, ln_l;
  logic       hs_s, vs_s, de_s, fr_s, req_s, nl_s;
  logic [3:0] r_s, g_s, b_s;
  logic [9:0] sx_s, sy_s, ln_s;
  logic [11:0] rgb_a, rgb_l, rgb_s, pix_l;
  logic [9:0] xp1 = '0, xp2 = '0, xp3 = '0;

  assign rgb_a = {r_a, g_a, b_a};
  assign rgb_l = {r_l, g_l, b_l};
  assign rgb_s = {r_s, g_s, b_s};

  // Fetch model for u_l: data for a request returns 3 cycles later.
  always @(posedge gclk) begin
    xp1 <= sx_l;
    xp2 <= xp1;
    xp3 <= xp2;
  end
  assign pix_l = {2'b00, xp3};

  vga_timing_gen #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
                   .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)) u_a (
    .gclk(gclk), .grst(grst), .en_i(en), .hs_o(hs_a), .vs_o(vs_a), .de_o(de_a),
    .fr_o(fr_a), .r_o(r_a), .g_o(g_a), .b_o(b_a), .req_o(req_a), .src_x_o(sx_a),
    .src_y_o(sy_a), .newline_o(nl_a), .line_o(ln_a), .pixel_i(PIX_A));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
                   .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
                   .HS_POL(1'b1), .VS_POL(1'b1), .FETCH_LAT(3)) u_l (
    .gclk(gclk), .grst(grst), .en_i(en), .hs_o(hs_l), .vs_o(vs_l), .de_o(de_l),
    .fr_o(fr_l), .r_o(r_l), .g_o(g_l), .b_o(b_l), .req_o(req_l), .src_x_o(sx_l),
    .src_y_o(sy_l), .newline_o(nl_l), .line_o(ln_l), .pixel_i(pix_l));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
                   .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
                   .SCALE(1)) u_s (
    .gclk(gclk), .grst(grst), .en_i(en), .hs_o(hs_s), .vs_o(vs_s), .de_o(de_s),
    .fr_o(fr_s), .r_o(r_s), .g_o(g_s), .b_o(b_s), .req_o(req_s), .src_x_o(sx_s),
    .src_y_o(sy_s), .newline_o(nl_s), .line_o(ln_s), .pixel_i(PIX_S));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    nchk++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_hs_a"}, hs_a, 1);  chk({t, "_vs_a"}, vs_a, 1);
    chk({t, "_de_a"}, de_a, 0);  chk({t, "_fr_a"}, fr_a, 0);
    chk({t, "_req_a"}, req_a, 0); chk({t, "_nl_a"}, nl_a, 0);
    chk({t, "_rgb_a"}, rgb_a, 0); chk({t, "_sx_a"}, sx_a, 0);
    chk({t, "_sy_a"}, sy_a, 0);  chk({t, "_ln_a"}, ln_a, 0);
    chk({t, "_hs_l"}, hs_l, 0);  chk({t, "_vs_l"}, vs_l, 0);
    chk({t, "_rgb_l"}, rgb_l, 0); chk({t, "_nl_s"}, nl_s, 0);
    chk({t, "_ln_s"}, ln_s, 0);
  endtask

  // p = cycles since the counters started at (0,0); all three DUTs share en.
  task automatic sample_check(input int p);
    int hc, vc, nv, q, hq, vq;
    logic rq, nl, dq, e_hs, e_vs, e_fr;
    hc = p % HT;
    vc = (p / HT) % VT;
    nv = (vc + 1) % VT;
    rq = (hc < HA) && (vc < VA);
    nl = (hc == HT - 1) && (nv < VA);
    chk("req_a", req_a, rq); chk("sx_a", sx_a, rq ? hc : 0); chk("sy_a", sy_a, rq ? vc : 0);
    chk("nl_a", nl_a, nl);
    if (nl) chk("ln_a", ln_a, nv);
    chk("req_l", req_l, rq); chk("sx_l", sx_l, rq ? hc : 0); chk("sy_l", sy_l, rq ? vc : 0);
    chk("nl_l", nl_l, nl);
    if (nl) chk("ln_l", ln_l, nv);
    chk("req_s", req_s, rq); chk("sx_s", sx_s, rq ? hc / 2 : 0); chk("sy_s", sy_s, rq ? vc / 2 : 0);
    nl = nl && (nv % 2 == 0);
    chk("nl_s", nl_s, nl);
    if (nl) chk("ln_s", ln_s, nv / 2);
    // u_a / u_s display latency 3 (FETCH_LAT=2 plus output register).
    dq = 0; e_hs = 0; e_vs = 0; e_fr = 0;
    if (p >= 3) begin
      q = p - 3; hq = q % HT; vq = (q / HT) % VT;
      dq   = (hq < HA) && (vq < VA);
      e_hs = (hq >= HA + HF) && (hq < HA + HF + HSY);
      e_vs = (vq >= VA + VF) && (vq < VA + VF + VSY);
      e_fr = (q % FT == 0);
    end
    chk("de_a", de_a, dq); chk("hs_a", hs_a, !e_hs); chk("vs_a", vs_a, !e_vs);
    chk("fr_a", fr_a, e_fr); chk("rgb_a", rgb_a, dq ? PIX_A : 0);
    chk("de_s", de_s, dq); chk("hs_s", hs_s, !e_hs); chk("vs_s", vs_s, !e_vs);
    chk("fr_s", fr_s, e_fr); chk("rgb_s", rgb_s, dq ? PIX_S : 0);
    // u_l display latency 4, active-high sync, data = source x.
    dq = 0; e_hs = 0; e_vs = 0; e_fr = 0; hq = 0;
    if (p >= 4) begin
      q = p - 4; hq = q % HT; vq = (q / HT) % VT;
      dq   = (hq < HA) && (vq < VA);
      e_hs = (hq >= HA + HF) && (hq < HA + HF + HSY);
      e_vs = (vq >= VA + VF) && (vq < VA + VF + VSY);
      e_fr = (q % FT == 0);
    end
    chk("de_l", de_l, dq); chk("hs_l", hs_l, e_hs); chk("vs_l", vs_l, e_vs);
    chk("fr_l", fr_l, e_fr); chk("rgb_l", rgb_l, dq ? hq : 0);
  endtask

  int fr0, fr1, nls, l0p, dr, hl, hsl, vsl;

  task automatic run_seg(input int n);
    fr0 = -1; fr1 = -1; nls = 0; l0p = -1; dr = -1; hl = -1; hsl = 0; vsl = 0;
    for (int p = 0; p < n; p++) begin
      @(negedge gclk);
      sample_check(p);
      if (fr_a) begin
        if (fr0 < 0) fr0 = p;
        else if (fr1 < 0) fr1 = p;
      end
      if (de_a && dr < 0) dr = p;
      if (!hs_a && hl < 0) hl = p;
      if (!hs_a && p < HT) hsl++;
      if (!vs_a && p < FT) vsl++;
      if (nl_s && p < FT) begin
        nls++;
        if (ln_s == 0 && l0p < 0) l0p = p;
      end
    end
  endtask

  initial begin
    int p;
    repeat (3) @(posedge gclk);
    @(negedge gclk);
    chk_reset("rst");

    grst = 1'b0;
    en   = 1'b1;
    run_seg(700);
    chk("fr_first", fr0, 3);
    chk("fr_period", fr1 - fr0, FT);
    chk("hs_ofs", hl - dr, HA + HF);
    chk("hs_width", hsl, HSY);
    chk("vs_width", vsl, VSY * HT);
    chk("nl_count", nls, VA / 2);
    chk("nl_row0_pos", l0p, FT - 1);

    // Continue to (vcount 3, hcount 10), then drop en.
    p = 700;
    forever begin
      @(negedge gclk);
      sample_check(p);
      if (p % FT == 3 * HT + 10) break;
      p++;
    end
    en = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge gclk);
      chk("drop_req", req_a, 0);
      chk("drop_sx", sx_a, 0);
      chk("drop_nl", nl_a, 0);
      chk("drop_de_a", de_a, j <= 3);
      chk("drop_de_l", de_l, j <= 4);
      if (j >= 5) chk("drop_hs", hs_a, 1);
    end
    en = 1'b1;
    run_seg(330);
    chk("reen_fr", fr0, 3);
    chk("reen_period", fr1 - fr0, FT);

    // Async reset pulse between clock edges, en held high.
    #2 grst = 1'b1;
    #1 chk_reset("arst");
    #1 grst = 1'b0;
    run_seg(330);
    chk("arst_fr", fr0, 3);
    chk("arst_period", fr1 - fr0, FT);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
